// File: rtl/vga_fb_addr_gen.sv
// Frame-buffer read-address generator: walks a stored IMG_W x IMG_H image in raster,
// 2x upscale, horizontal-mirror or vertical-flip order, one pixel per pix_req.
module vga_fb_addr_gen #(
   parameter int IMG_W  = 400,
   parameter int IMG_H  = 300,
   parameter int ADDR_W = 19
) (
   input  logic              clk_25mHz,
   input  logic              rst_n,
   input  logic              ready,
   input  logic              pix_req,
   input  logic [1:0]        cmd,
   output logic [ADDR_W-1:0] addr,
   output logic [1:0]        mode_q,
   output logic              line_done,
   output logic              frame_done
);

   localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [1:0] MODE_RASTER  = 2'd0;
   localparam logic [1:0] MODE_UPSCALE = 2'd1;
   localparam logic [1:0] MODE_MIRROR  = 2'd2;
   localparam logic [1:0] MODE_VFLIP   = 2'd3;

   localparam logic [X_W-1:0]    X_ZERO    = {X_W{1'b0}};
   localparam logic [Y_W-1:0]    Y_ZERO    = {Y_W{1'b0}};
   localparam logic [ADDR_W-1:0] A_ZERO    = {ADDR_W{1'b0}};
   localparam logic [X_W-1:0]    LAST_X    = X_W'(IMG_W - 1);
   localparam logic [Y_W-1:0]    LAST_Y    = Y_W'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
   // Elaboration-time constant: no multiplier is built.
   localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((IMG_H - 1) * IMG_W);

   logic [X_W-1:0]    x_r, x_s, start_x_s;
   logic [Y_W-1:0]    y_r, y_s, start_y_s;
   logic [ADDR_W-1:0] base_r, base_s, start_base_s;
   logic              hsub_r, hsub_s, vsub_r, vsub_s;
   logic [1:0]        mode_s;
   logic              line_s, frame_s;

   // Start position of the mode requested on cmd.
   always_comb begin
      start_x_s    = X_ZERO;
      start_y_s    = Y_ZERO;
      start_base_s = A_ZERO;
      case (cmd)
         MODE_MIRROR: begin
            start_x_s = LAST_X;
         end
         MODE_VFLIP: begin
            start_y_s    = LAST_Y;
            start_base_s = LAST_BASE;
         end
         default: begin
            start_x_s = X_ZERO;
         end
      endcase
   end

   // Next scan position, line/frame pulses and restart selection.
   always_comb begin
      x_s     = x_r;
      y_s     = y_r;
      base_s  = base_r;
      hsub_s  = hsub_r;
      vsub_s  = vsub_r;
      mode_s  = mode_q;
      line_s  = 1'b0;
      frame_s = 1'b0;
      if (ready && pix_req) begin
         case (mode_q)
            MODE_RASTER: begin
               if (x_r == LAST_X) begin
                  x_s    = X_ZERO;
                  line_s = 1'b1;
                  if (y_r == LAST_Y) begin
                     frame_s = 1'b1;
                  end else begin
                     y_s    = y_r + Y_W'(1'b1);
                     base_s = base_r + ROW_STEP;
                  end
               end else begin
                  x_s = x_r + X_W'(1'b1);
               end
            end
            MODE_UPSCALE: begin
               hsub_s = ~hsub_r;
               if (hsub_r && (x_r == LAST_X)) begin
                  x_s    = X_ZERO;
                  line_s = 1'b1;
                  vsub_s = ~vsub_r;
                  if (vsub_r && (y_r == LAST_Y)) begin
                     frame_s = 1'b1;
                  end else if (vsub_r) begin
                     y_s    = y_r + Y_W'(1'b1);
                     base_s = base_r + ROW_STEP;
                  end else begin
                     y_s = y_r;
                  end
               end else if (hsub_r) begin
                  x_s = x_r + X_W'(1'b1);
               end else begin
                  x_s = x_r;
               end
            end
            MODE_MIRROR: begin
               if (x_r == X_ZERO) begin
                  x_s    = LAST_X;
                  line_s = 1'b1;
                  if (y_r == LAST_Y) begin
                     frame_s = 1'b1;
                  end else begin
                     y_s    = y_r + Y_W'(1'b1);
                     base_s = base_r + ROW_STEP;
                  end
               end else begin
                  x_s = x_r - X_W'(1'b1);
               end
            end
            default: begin
               if (x_r == LAST_X) begin
                  x_s    = X_ZERO;
                  line_s = 1'b1;
                  if (y_r == Y_ZERO) begin
                     frame_s = 1'b1;
                  end else begin
                     y_s    = y_r - Y_W'(1'b1);
                     base_s = base_r - ROW_STEP;
                  end
               end else begin
                  x_s = x_r + X_W'(1'b1);
               end
            end
         endcase
      end else begin
         line_s = 1'b0;
      end
      // Display not ready or frame wrapped: reload from the freshly sampled cmd.
      if (!ready || frame_s) begin
         x_s    = start_x_s;
         y_s    = start_y_s;
         base_s = start_base_s;
         hsub_s = 1'b0;
         vsub_s = 1'b0;
         mode_s = cmd;
      end else begin
         mode_s = mode_q;
      end
   end

   // Scan state and registered outputs.
   always_ff @(posedge clk_25mHz or negedge rst_n) begin
      if (!rst_n) begin
         x_r        <= X_ZERO;
         y_r        <= Y_ZERO;
         base_r     <= A_ZERO;
         hsub_r     <= 1'b0;
         vsub_r     <= 1'b0;
         mode_q     <= MODE_RASTER;
         addr       <= A_ZERO;
         line_done  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         x_r        <= x_s;
         y_r        <= y_s;
         base_r     <= base_s;
         hsub_r     <= hsub_s;
         vsub_r     <= vsub_s;
         mode_q     <= mode_s;
         addr       <= base_s + ADDR_W'(x_s);
         line_done  <= line_s;
         frame_done <= frame_s;
      end
   end

endmodule

// File: tb/tb_vga_fb_addr_gen.sv
// Scoreboard bench for vga_fb_addr_gen on a small 6x4 image so whole frames fit in a short run.
module tb_vga_fb_addr_gen;

   localparam int W  = 6;
   localparam int H  = 4;
   localparam int AW = 5;

   logic          clk_25mHz = 1'b0;
   logic          rst_n     = 1'b0;
   logic          ready     = 1'b0;
   logic          pix_req   = 1'b0;
   logic [1:0]    cmd       = 2'd0;
   logic [AW-1:0] addr;
   logic [1:0]    mode_q;
   logic          line_done;
   logic          frame_done;

   vga_fb_addr_gen #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk_25mHz (clk_25mHz),
      .rst_n     (rst_n),
      .ready     (ready),
      .pix_req   (pix_req),
      .cmd       (cmd),
      .addr      (addr),
      .mode_q    (mode_q),
      .line_done (line_done),
      .frame_done(frame_done)
   );

   always #20 clk_25mHz = ~clk_25mHz;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [1:0]    mode;
      logic          ld;
      logic          fd;
   } exp_t;

   exp_t sb[$];
   int   sb_step[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   m_mode     = 0;
   int   m_idx      = 0;
   int   step_no    = 0;

   // Address of displayed pixel i of a frame, written straight from the scan definitions.
   function automatic int exp_addr(input int m, input int i);
      case (m)
         0:       return i;
         1:       return ((i / (2 * W)) / 2) * W + (i % (2 * W)) / 2;
         2:       return (i / W) * W + (W - 1 - i % W);
         default: return (H - 1 - i / W) * W + i % W;
      endcase
   endfunction

   function automatic int line_len(input int m);
      return (m == 1) ? 2 * W : W;
   endfunction

   function automatic int frame_len(input int m);
      return (m == 1) ? 4 * W * H : W * H;
   endfunction

   task automatic step(input logic r_n, input logic rdy, input logic req, input logic [1:0] c);
      exp_t e;
      @(negedge clk_25mHz);
      rst_n   = r_n;
      ready   = rdy;
      pix_req = req;
      cmd     = c;
      e.ld = 1'b0;
      e.fd = 1'b0;
      if (!r_n) begin
         m_mode = 0;
         m_idx  = 0;
      end else if (!rdy) begin
         m_mode = int'(c);
         m_idx  = 0;
      end else if (req) begin
         m_idx++;
         e.ld = ((m_idx % line_len(m_mode)) == 0);
         if (m_idx == frame_len(m_mode)) begin
            e.fd   = 1'b1;
            m_idx  = 0;
            m_mode = int'(c);
         end
      end
      e.addr = AW'(exp_addr(m_mode, m_idx));
      e.mode = 2'(m_mode);
      step_no++;
      sb.push_back(e);
      sb_step.push_back(step_no);
   endtask

   // n pixel requests with an idle cycle slipped in every fifth slot
   task automatic reqs(input int n, input logic [1:0] c);
      for (int k = 0; k < n; k++) begin
         if ((k % 5) == 4) step(1'b1, 1'b1, 1'b0, c);
         step(1'b1, 1'b1, 1'b1, c);
      end
   endtask

   task automatic async_reset_check();
      @(posedge clk_25mHz);
      #5;
      rst_n = 1'b0;
      #1;
      compared++;
      if (addr !== '0 || mode_q !== 2'd0 || line_done !== 1'b0 || frame_done !== 1'b0) begin
         mismatched++;
         $display("FAIL async_reset: got addr=%0d mode=%0d line=%0b frame=%0b, want all zero",
                  addr, mode_q, line_done, frame_done);
      end
   endtask

   // Monitor: every cycle the DUT presents a new registered state; compare it to the queued expectation.
   initial begin
      exp_t e;
      int   n;
      forever begin
         @(posedge clk_25mHz);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n = sb_step.pop_front();
            compared++;
            if (addr !== e.addr || mode_q !== e.mode || line_done !== e.ld || frame_done !== e.fd) begin
               mismatched++;
               $display("FAIL step%0d: got addr=%0d mode=%0d line=%0b frame=%0b, want addr=%0d mode=%0d line=%0b frame=%0b",
                        n, addr, mode_q, line_done, frame_done, e.addr, e.mode, e.ld, e.fd);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset, then idle with ready high: reset state must hold
      repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0);
      repeat (2) step(1'b1, 1'b1, 1'b0, 2'd0);
      // raster: full frame plus a few pixels of the next
      reqs(W * H + 3, 2'd0);
      // cmd switched to mirror mid-frame: takes effect only at the wrap
      reqs(W * H - 3, 2'd2);
      // mirror: full frame and into the next
      reqs(W * H + 2, 2'd2);
      // asynchronous reset while mid-frame in mirror mode
      async_reset_check();
      step(1'b0, 1'b0, 1'b0, 2'd2);
      // vflip via a not-ready restart
      step(1'b1, 1'b0, 1'b0, 2'd3);
      reqs(W * H + 2, 2'd3);
      // 2x upscale
      step(1'b1, 1'b0, 1'b0, 2'd1);
      reqs(4 * W * H + 3, 2'd1);
      // raster, then ready dropped mid-frame with pix_req held high
      step(1'b1, 1'b0, 1'b0, 2'd0);
      reqs(7, 2'd0);
      step(1'b1, 1'b0, 1'b1, 2'd2);
      step(1'b1, 1'b0, 1'b1, 2'd2);
      step(1'b1, 1'b1, 1'b0, 2'd2);
      reqs(3, 2'd2);
      step(1'b1, 1'b1, 1'b0, 2'd2);
      repeat (3) @(negedge clk_25mHz);
      compared++;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
